// File: rtl/imem_loader.sv
// Instruction-memory writer: takes a length-prefixed, checksummed byte stream and
// writes it as big-endian 32-bit words to consecutive word addresses from 0.
module imem_loader #(
  parameter int DEPTH = 128,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [2:0]       state;
  logic [CNT_W-1:0] len;
  logic [1:0]       byte_idx;
  logic [7:0]       xor_acc;
  logic [23:0]      shreg;
  logic [CNT_W-1:0] len_in;
  logic [CNT_W-1:0] count_inc;
  logic             accept;

  assign byte_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign accept     = byte_valid & byte_ready;
  assign busy       = (state != S_IDLE);
  assign len_in     = CNT_W'(byte_data);
  assign count_inc  = word_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      byte_idx   <= '0;
      xor_acc    <= '0;
      shreg      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LEN;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            byte_idx   <= '0;
            xor_acc    <= '0;
            len        <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            if ((len_in == '0) || (len_in > DEPTH_C)) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              len   <= len_in;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            xor_acc  <= xor_acc ^ byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // word_count doubles as the write address of the word being completed
              wr_en      <= 1'b1;
              wr_addr    <= 32'(word_count);
              wr_data    <= {shreg, byte_data};
              word_count <= count_inc;
              if (count_inc == len) state <= S_CSUM;
            end else begin
              shreg <= {shreg[15:0], byte_data};
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (byte_data == xor_acc) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: state <= S_IDLE;
        default:       state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares them whenever wr_en is seen.
module tb_imem_loader;
  localparam int DEPTH = 128;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = '0;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] word_count;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write monitor
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%h data=%h required=no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e[63:32]);
          chk("wr_data", wr_data, e[31:0]);
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
    chk({tag, "_wr_addr"},    wr_addr,         32'd0);
    chk({tag, "_wr_data"},    wr_data,         32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_error"},      32'(error),      32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic do_start(input bit with_byte);
    @(negedge clk);
    start = 1'b1;
    if (with_byte) begin
      byte_valid = 1'b1;
      byte_data  = 8'h55;
    end
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
  endtask

  // gap idle cycles precede the byte; sp drives start during those idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap, input bit sp);
    int t;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
      start      = sp;
    end
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  // Sends L, n words, checksum. use_c forces checksum c_val; stall_word gets 1-cycle gaps.
  task automatic run_image(input int n, input bit use_c, input logic [7:0] c_val,
                           input int stall_word, input bit exp_ok, input bit start_byte);
    logic [7:0]  c;
    logic [31:0] wd;
    c = 8'h00;
    do_start(start_byte);
    send_byte(8'(n), 0, 1'b0);
    for (int w = 0; w < n; w++) begin
      wd = img[w];
      exp_q.push_back({32'(w), wd});
      for (int b = 0; b < 4; b++) begin
        c = c ^ wd[31-8*b -: 8];
        send_byte(wd[31-8*b -: 8], (w == stall_word) ? 1 : 0, (w == stall_word) && (b == 1));
      end
    end
    send_byte(use_c ? c_val : c, 0, 1'b0);
    wait_idle();
    chk("done",       32'(done),       32'(exp_ok));
    chk("error",      32'(error),      32'(!exp_ok));
    chk("word_count", 32'(word_count), 32'(n));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic bad_len(input logic [7:0] l);
    do_start(1'b0);
    send_byte(l, 0, 1'b0);
    chk("badlen_error", 32'(error), 32'd1);
    chk("badlen_done",  32'(done),  32'd0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("badlen_ready", 32'(byte_ready), 32'd0);
    chk("badlen_count", 32'(word_count), 32'd0);
  endtask

  initial begin
    #3;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: good two-word image, start coincides with a stray byte
    img[0] = 32'h04100000;
    img[1] = 32'h04181002;
    run_image(2, 1'b0, 8'h00, -1, 1'b1, 1'b1);

    // 2: same image, wrong checksum; writes still land
    run_image(2, 1'b1, 8'hFF, -1, 1'b0, 1'b0);

    // 3: length out of range
    bad_len(8'd0);
    bad_len(8'd129);

    // 4: full-depth image of random data
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    run_image(DEPTH, 1'b0, 8'h00, -1, 1'b1, 1'b0);
    chk("last_wr_addr", wr_addr, 32'd127);

    // 5: stalled stream on word 1 with a start pulse mid-load
    img[0] = 32'hDEADBEEF;
    img[1] = 32'h12345678;
    img[2] = 32'hA5A55A5A;
    run_image(3, 1'b0, 8'h00, 1, 1'b1, 1'b0);

    // 6: asynchronous reset part-way through word 1, then a clean reload
    img[0] = 32'h04100000;
    img[1] = 32'h04181002;
    do_start(1'b0);
    send_byte(8'd2, 0, 1'b0);
    exp_q.push_back({32'd0, img[0]});
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h18, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_image(2, 1'b0, 8'h00, -1, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
